// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port plus the decode-side
// valid/ready output stage, redirect request and status.
interface instr_fetch_unit_if;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halted_o;
  logic [31:0] fetch_count_o;

  modport master (
    output pc_addr_o, instr_o, pc_o, pc_plus4_o, valid_o, halted_o, fetch_count_o,
    input  instr_i, ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  pc_addr_o, instr_o, pc_o, pc_plus4_o, valid_o, halted_o, fetch_count_o,
    output instr_i, ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-entry output stage with valid/ready,
// redirect flush, end-of-program halt and delivered-instruction counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_fetch_unit_if.master    bus
);

  localparam logic [31:0] LAST_ADDR = 32'(4 * MEM_WORDS - 4);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic handshake;
  logic slot_free;
  logic out_of_range;
  logic zero_word;

  assign handshake    = valid_q & bus.ready_i;
  assign slot_free    = ~valid_q | bus.ready_i;
  assign out_of_range = pc_q > LAST_ADDR;
  assign zero_word    = HALT_ON_ZERO && (bus.instr_i == 32'h0);

  // Next-state: first matching rule wins (redirect, halt, range, zero, fetch, stall)
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q + 32'(handshake);

    if (bus.redirect_i) begin
      pc_d    = bus.redirect_pc_i & ~32'h3;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == HALT) begin
      if (handshake) valid_d = 1'b0;
    end else if (slot_free) begin
      if (out_of_range || zero_word) begin
        state_d = HALT;
        if (bus.ready_i) valid_d = 1'b0;
      end else begin
        instr_d  = bus.instr_i;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
      count_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_addr_o     = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_out_q;
  assign bus.pc_plus4_o    = pc_out_q + 32'd4;
  assign bus.valid_o       = valid_q;
  assign bus.halted_o      = (state_q == HALT);
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: unit A halts on zero words, unit B halts only on range.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  instr_fetch_unit_if bus_a ();
  instr_fetch_unit_if bus_b ();

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32), .HALT_ON_ZERO(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a)
  );
  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32), .HALT_ON_ZERO(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Combinational instruction memories
  always_comb begin
    bus_a.instr_i = (bus_a.pc_addr_o < 32'h80) ? mem_a[bus_a.pc_addr_o[6:2]] : 32'hDEAD_BEEF;
    bus_b.instr_i = (bus_b.pc_addr_o < 32'h80) ? mem_b[bus_b.pc_addr_o[6:2]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    mem_a[0] = 32'h2008_0005;
    mem_a[1] = 32'h2009_0003;
    mem_a[2] = 32'h0109_5020;
    mem_a[3] = 32'h0000_0000;
    for (int i = 4; i < 32; i++) mem_a[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 32; i++) mem_b[i] = 32'hA000_0000 + 32'(i);

    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.ready_i = 1'b1; bus_a.redirect_i = 1'b0; bus_a.redirect_pc_i = 32'h0;
    bus_b.ready_i = 1'b1; bus_b.redirect_i = 1'b0; bus_b.redirect_pc_i = 32'h0;
    @(negedge clk);
    tick();

    // Reset values
    chk("rst_valid", 32'(bus_a.valid_o), 32'd0);
    chk("rst_instr", bus_a.instr_o, 32'h0);
    chk("rst_pc", bus_a.pc_o, 32'h0);
    chk("rst_halted", 32'(bus_a.halted_o), 32'd0);
    chk("rst_count", bus_a.fetch_count_o, 32'd0);
    chk("rst_pcaddr", bus_a.pc_addr_o, 32'h0);

    // Sequential fetch, halt on zero word at 12
    rst_a = 1'b1;
    tick();
    chk("seq0_valid", 32'(bus_a.valid_o), 32'd1);
    chk("seq0_pc", bus_a.pc_o, 32'h0);
    chk("seq0_instr", bus_a.instr_o, 32'h2008_0005);
    chk("seq0_pc4", bus_a.pc_plus4_o, 32'h4);
    chk("seq0_count", bus_a.fetch_count_o, 32'd0);
    tick();
    chk("seq1_pc", bus_a.pc_o, 32'h4);
    chk("seq1_instr", bus_a.instr_o, 32'h2009_0003);
    chk("seq1_count", bus_a.fetch_count_o, 32'd1);
    tick();
    chk("seq2_pc", bus_a.pc_o, 32'h8);
    chk("seq2_instr", bus_a.instr_o, 32'h0109_5020);
    chk("seq2_pcaddr", bus_a.pc_addr_o, 32'hC);
    tick();
    chk("halt_halted", 32'(bus_a.halted_o), 32'd1);
    chk("halt_valid", 32'(bus_a.valid_o), 32'd0);
    chk("halt_count", bus_a.fetch_count_o, 32'd3);
    chk("halt_pcaddr", bus_a.pc_addr_o, 32'hC);
    tick();
    chk("halt_hold_pcaddr", bus_a.pc_addr_o, 32'hC);
    chk("halt_hold_count", bus_a.fetch_count_o, 32'd3);
    chk("halt_hold_valid", 32'(bus_a.valid_o), 32'd0);

    // Backpressure at pc_o=4
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
    tick();
    chk("bp_pre_pc", bus_a.pc_o, 32'h4);
    bus_a.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", bus_a.pc_o, 32'h4);
      chk("bp_instr", bus_a.instr_o, 32'h2009_0003);
      chk("bp_pcaddr", bus_a.pc_addr_o, 32'h8);
      chk("bp_count", bus_a.fetch_count_o, 32'd1);
      chk("bp_valid", 32'(bus_a.valid_o), 32'd1);
    end
    bus_a.ready_i = 1'b1;
    tick();
    chk("bp_rel_count", bus_a.fetch_count_o, 32'd2);
    chk("bp_rel_pc", bus_a.pc_o, 32'h8);

    // Redirect with concurrent handshake
    bus_a.redirect_i = 1'b1;
    bus_a.redirect_pc_i = 32'h17;
    tick();
    bus_a.redirect_i = 1'b0;
    chk("rd_valid", 32'(bus_a.valid_o), 32'd0);
    chk("rd_count", bus_a.fetch_count_o, 32'd3);
    chk("rd_pcaddr", bus_a.pc_addr_o, 32'h14);
    tick();
    chk("rd_tgt_valid", 32'(bus_a.valid_o), 32'd1);
    chk("rd_tgt_pc", bus_a.pc_o, 32'h14);
    chk("rd_tgt_pc4", bus_a.pc_plus4_o, 32'h18);
    chk("rd_tgt_instr", bus_a.instr_o, 32'h1000_0005);
    chk("rd_tgt_count", bus_a.fetch_count_o, 32'd3);

    // Mid-run reset with count=5
    tick();
    tick();
    chk("mr_pre_count", bus_a.fetch_count_o, 32'd5);
    chk("mr_pre_valid", 32'(bus_a.valid_o), 32'd1);
    rst_a = 1'b0;
    tick();
    chk("mr_valid", 32'(bus_a.valid_o), 32'd0);
    chk("mr_count", bus_a.fetch_count_o, 32'd0);
    chk("mr_pcaddr", bus_a.pc_addr_o, 32'h0);
    chk("mr_halted", 32'(bus_a.halted_o), 32'd0);
    chk("mr_pc", bus_a.pc_o, 32'h0);

    // Halt deferred behind a pending output
    rst_a = 1'b1;
    tick();
    tick();
    tick();
    chk("hp_pre_pc", bus_a.pc_o, 32'h8);
    bus_a.ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hp_halted", 32'(bus_a.halted_o), 32'd0);
      chk("hp_valid", 32'(bus_a.valid_o), 32'd1);
      chk("hp_pc", bus_a.pc_o, 32'h8);
      chk("hp_pcaddr", bus_a.pc_addr_o, 32'hC);
    end
    bus_a.ready_i = 1'b1;
    tick();
    chk("hp_done_halted", 32'(bus_a.halted_o), 32'd1);
    chk("hp_done_valid", 32'(bus_a.valid_o), 32'd0);
    chk("hp_done_count", bus_a.fetch_count_o, 32'd3);

    // Out-of-range halt on unit B
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("oor_pc", bus_b.pc_o, 32'(4 * i));
      chk("oor_instr", bus_b.instr_o, 32'hA000_0000 + 32'(i));
    end
    tick();
    chk("oor_halted", 32'(bus_b.halted_o), 32'd1);
    chk("oor_valid", 32'(bus_b.valid_o), 32'd0);
    chk("oor_pcaddr", bus_b.pc_addr_o, 32'h80);
    chk("oor_count", bus_b.fetch_count_o, 32'd32);
    bus_b.redirect_i = 1'b1;
    bus_b.redirect_pc_i = 32'h0;
    tick();
    bus_b.redirect_i = 1'b0;
    chk("oor_rd_halted", 32'(bus_b.halted_o), 32'd0);
    chk("oor_rd_pcaddr", bus_b.pc_addr_o, 32'h0);
    chk("oor_rd_valid", 32'(bus_b.valid_o), 32'd0);
    tick();
    chk("oor_rs_valid", 32'(bus_b.valid_o), 32'd1);
    chk("oor_rs_pc", bus_b.pc_o, 32'h0);
    chk("oor_rs_instr", bus_b.instr_o, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
